// File: rtl/seq_detector_param_if.sv
// Bus bundle for seq_detector_param.
// Handshake: a bit on din is consumed on a rising clk edge only when din_valid is 1;
// there is no back-pressure, so the detector accepts every valid bit. pat_load takes
// priority over din_valid in the same cycle and drops that bit.
// Signals:
//   din, din_valid   serial bit and its qualifier (master -> detector)
//   overlap_en       1 = overlapping matches, 0 = restart after a match
//   pat_load, pat_in pattern reload strobe and new pattern (MSB = first bit)
//   dout             registered one-cycle match pulse
//   match_count      saturating match counter
//   count_sat        1 while match_count is all ones
//   armed            debug view of the FSM: 1 = ARMED, 0 = FILLING
interface seq_detector_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             din;
  logic             din_valid;
  logic             overlap_en;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             dout;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;
  logic             armed;

  modport master (
    output din, din_valid, overlap_en, pat_load, pat_in,
    input  dout, match_count, count_sat, armed
  );

  modport slave (
    input  din, din_valid, overlap_en, pat_load, pat_in,
    output dout, match_count, count_sat, armed
  );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector.
// Shifts qualified serial bits into a history register and raises a registered
// one-cycle pulse when the last PAT_W valid bits equal the loaded pattern.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (highest priority)
//   bus  seq_detector_param_if slave modport (data in, pattern load, match outputs)
// Parameters:
//   PAT_W    pattern length in bits (>=2)
//   PATTERN  pattern loaded at reset, MSB is the first bit received
//   CNT_W    match counter width (>=1)
module seq_detector_param #(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int             CNT_W   = 8
) (
  input logic                 clk,
  input logic                 rst,
  seq_detector_param_if.slave bus
);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W);
  localparam logic [FW-1:0] FILL_ARM = FW'(PAT_W - 1);

  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PAT_W-1:0] next_bits;
  logic             hit;

  assign next_bits = {hist_q[PAT_W-2:0], bus.din};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILLING;
      fill_q  <= '0;
      hist_q  <= '0;
      pat_q   <= PATTERN;
      dout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    fill_d = fill_q;
    hist_d = hist_q;
    pat_d  = pat_q;
    cnt_d  = cnt_q;
    dout_d = 1'b0;
    hit    = 1'b0;
    if (bus.pat_load) begin
      // Reload wipes all partial history so no match can span the load.
      pat_d  = bus.pat_in;
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (bus.din_valid) begin
      hist_d = next_bits;
      fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
      // fill gates the compare, so stale hist bits after a non-overlap
      // restart can never produce a match.
      hit    = (fill_q >= FILL_ARM) && (next_bits == pat_q);
      dout_d = hit;
      if (hit) begin
        if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
        if (!bus.overlap_en) fill_d = '0;
      end
    end
    state_d = (fill_d == FILL_MAX) ? ARMED : FILLING;
  end

  assign bus.dout        = dout_q;
  assign bus.match_count = cnt_q;
  assign bus.count_sat   = &cnt_q;
  assign bus.armed       = (state_q == ARMED);
endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) bus0 ();
  seq_detector_param_if #(.PAT_W(4), .CNT_W(2)) bus1 ();

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1111), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // ---------------- scoreboard / reference model ----------------
  // All valid bits ever accepted, in order. Each detector remembers where its
  // current matching segment starts; a match needs PAT_W bits inside the segment.
  int          checks = 0;
  int          errors = 0;
  int          step_no = 0;
  bit          hist_q[$];
  int          seg_start[2];
  logic [3:0]  mpat[2];
  int          mcnt[2];
  logic        mdout[2];
  logic [3:0]  pat_def[2];
  int          cnt_max[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step %0d: got %0h expected %0h", tag, step_no, obs, exp);
    end
  endtask

  task automatic model_clear(input bit to_default, input logic [3:0] p);
    for (int k = 0; k < 2; k++) begin
      mpat[k]      = to_default ? pat_def[k] : p;
      seg_start[k] = hist_q.size();
      mcnt[k]      = 0;
      mdout[k]     = 1'b0;
    end
  endtask

  task automatic model_bit(input bit d, input bit o);
    int sz;
    bit hit;
    hist_q.push_back(d);
    sz = hist_q.size();
    for (int k = 0; k < 2; k++) begin
      hit = (sz - seg_start[k]) >= 4;
      if (hit) begin
        for (int i = 0; i < 4; i++)
          if (hist_q[sz-4+i] != mpat[k][3-i]) hit = 1'b0;
      end
      mdout[k] = hit;
      if (hit && mcnt[k] < cnt_max[k]) mcnt[k]++;
      if (hit && !o) seg_start[k] = sz;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit ld, input logic [3:0] p,
                      input bit v, input bit d, input bit o);
    rst = r;
    bus0.pat_load = ld; bus1.pat_load = ld;
    bus0.pat_in = p;    bus1.pat_in = p;
    bus0.din_valid = v; bus1.din_valid = v;
    bus0.din = d;       bus1.din = d;
    bus0.overlap_en = o; bus1.overlap_en = o;
    @(posedge clk);
    step_no++;
    if (r)       model_clear(1'b1, 4'b0000);
    else if (ld) model_clear(1'b0, p);
    else if (v)  model_bit(d, o);
    else begin
      mdout[0] = 1'b0;
      mdout[1] = 1'b0;
    end
    #1;
    check("dout0",  32'(bus0.dout), 32'(mdout[0]));
    check("count0", 32'(bus0.match_count), 32'(mcnt[0]));
    check("sat0",   32'(bus0.count_sat), 32'(mcnt[0] == cnt_max[0]));
    check("armed0", 32'(bus0.armed), 32'((hist_q.size() - seg_start[0]) >= 4));
    check("dout1",  32'(bus1.dout), 32'(mdout[1]));
    check("count1", 32'(bus1.match_count), 32'(mcnt[1]));
    check("sat1",   32'(bus1.count_sat), 32'(mcnt[1] == cnt_max[1]));
    check("armed1", 32'(bus1.armed), 32'((hist_q.size() - seg_start[1]) >= 4));
  endtask

  task automatic stream(input logic [31:0] bits, input int n, input bit o);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b0, 4'b0, 1'b1, bits[i], o);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    pat_def[0] = 4'b1011; pat_def[1] = 4'b1111;
    cnt_max[0] = 255;     cnt_max[1] = 3;
    model_clear(1'b1, 4'b0000);

    // reset state
    do_reset();
    check("rst_dout", 32'(bus0.dout), 32'd0);
    check("rst_count", 32'(bus0.match_count), 32'd0);
    check("rst_sat", 32'(bus0.count_sat), 32'd0);

    // default pattern detected one cycle after its last bit
    stream(32'b1011, 4, 1'b1);
    check("t1_pulse", 32'(bus0.dout), 32'd1);
    check("t1_count", 32'(bus0.match_count), 32'd1);
    step(1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1);
    check("t1_pulse_end", 32'(bus0.dout), 32'd0);

    // overlapping matches
    do_reset();
    stream(32'b1011011, 7, 1'b1);
    check("t2_count", 32'(bus0.match_count), 32'd2);

    // non-overlapping: second candidate reuses bits and is rejected
    do_reset();
    stream(32'b1011011, 7, 1'b0);
    check("t3_count", 32'(bus0.match_count), 32'd1);

    // idle gaps inside a match
    do_reset();
    stream(32'b10, 2, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0, 1'b0, 1'b1, 1'b1);
    stream(32'b11, 2, 1'b1);
    check("t4_count", 32'(bus0.match_count), 32'd1);

    // pattern reload mid-stream drops the same-cycle bit
    stream(32'b10, 2, 1'b1);
    step(1'b0, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b1);
    check("t5_cleared", 32'(bus0.match_count), 32'd0);
    stream(32'b0110, 4, 1'b1);
    check("t5_count", 32'(bus0.match_count), 32'd1);

    // saturation on the narrow counter
    do_reset();
    stream(32'hff, 8, 1'b1);
    check("t6_count", 32'(bus1.match_count), 32'd3);
    check("t6_sat", 32'(bus1.count_sat), 32'd1);
    check("t6_pulse", 32'(bus1.dout), 32'd1);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 59) == 0,
           4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
